mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 102 ++++++++++
 tb/tb_mem_access_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit for a 32-bit word memory with sub-word merge.
// Ports:
//   clk, clrn            clock and asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we, req_size, req_signed, req_addr, req_wdata  request fields
//   rsp_valid, rsp_rdata registered, extended load result
//   misalign_err         one-cycle pulse when an accepted request was dropped
//   mem_addr, mem_datain, mem_we, mem_dataout  data memory port (sync write, comb read)
module mem_access_unit #(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);
  typedef enum logic {IDLE, MERGE} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        rsp_valid_q, rsp_valid_d, err_q, err_d, we;
  logic        accept, word, mis;
  logic [31:0] lane_mask, lane_data, byte_sh, half_sh, load_val;
  assign accept = req_valid & (state_q == IDLE);
  assign word   = req_size[1];
  assign mis    = MISALIGN_CHECK & (word ? |req_addr[1:0] : req_size[0] & req_addr[0]);
  // Sub-word store data is replicated across all lanes; the mask picks the target lane.
  assign lane_mask = size_q[0] ? 32'hFFFF << {addr_q[1], 4'b0} : 32'hFF << {addr_q[1:0], 3'b0};
  assign lane_data = size_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  assign byte_sh   = mem_dataout >> {req_addr[1:0], 3'b0};
  assign half_sh   = mem_dataout >> {req_addr[1], 4'b0};
  assign load_val  = word ? mem_dataout :
                     req_size[0] ? {{16{req_signed & half_sh[15]}}, half_sh[15:0]} :
                                   {{24{req_signed & byte_sh[7]}}, byte_sh[7:0]};
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    err_d       = 1'b0;
    mem_addr    = req_addr;
    mem_datain  = req_wdata;
    we          = 1'b0;
    if (state_q == MERGE) begin
      mem_addr   = addr_q;
      mem_datain = (mem_dataout & ~lane_mask) | (lane_data & lane_mask);
      we         = 1'b1;
      state_d    = IDLE;
    end else if (accept) begin
      if (mis) err_d = 1'b1;
      else if (!req_we) begin
        rsp_valid_d = 1'b1;
        rdata_d     = load_val;
      end else if (word) we = 1'b1;
      else begin
        state_d = MERGE;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        size_d  = req_size;
      end
    end
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end
  // Reset must kill a pending merge write immediately, not at the next edge.
  assign mem_we       = we & clrn;
  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign misalign_err = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random checks of mem_access_unit against a lane-level memory model.
module tb_mem_access_unit;
  logic        clk = 1'b0, clrn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, misalign_err, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_datain, mem_dataout;
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic [31:0] last_rd = '0;
  int checks = 0, failures = 0;

  mem_access_unit dut (
    .clk(clk), .clrn(clrn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .misalign_err(misalign_err), .mem_addr(mem_addr),
    .mem_datain(mem_datain), .mem_we(mem_we), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) if (mem_we) mem[mem_addr[6:2]] <= mem_datain;
  assign mem_dataout = mem[mem_addr[6:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit misaligned(input logic [1:0] size, input logic [31:0] a);
    if (size >= 2) return a % 4 != 0;
    if (size == 1) return a % 2 != 0;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                           input bit sgn, input logic [31:0] a);
    logic [31:0] v;
    if (size >= 2) return w;
    if (size == 1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      return (sgn && v >= 32'h8000) ? v + 32'hFFFF0000 : v;
    end
    v = (w >> (8 * (a % 4))) & 32'hFF;
    return (sgn && v >= 32'h80) ? v + 32'hFFFFFF00 : v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] size,
                                            input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r = w;
    for (int k = 0; k < 4; k++) begin
      if (size >= 2) r[8*k +: 8] = d[8*k +: 8];
      else if (size == 1 && k / 2 == (a / 2) % 2) r[8*k +: 8] = d[8*(k%2) +: 8];
      else if (size == 0 && k == a % 4) r[8*k +: 8] = d[7:0];
    end
    return r;
  endfunction

  task automatic op(input bit we, input logic [1:0] size, input bit sgn,
                    input logic [31:0] a, input logic [31:0] d);
    bit m = misaligned(size, a);
    bit sub = we && size < 2 && !m;
    int idx = int'(a[6:2]);
    logic [31:0] exp = ref_load(ref_mem[idx], size, sgn, a);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = a; req_wdata = d;
    @(negedge clk);
    chk("ready_acc", {31'b0, req_ready}, 32'd1);
    chk("we_acc", {31'b0, mem_we}, {31'b0, we && size >= 2 && !m});
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = $urandom;
    if (we && !m) ref_mem[idx] = ref_store(ref_mem[idx], size, a, d);
    @(negedge clk);
    chk("ready_nxt", {31'b0, req_ready}, {31'b0, !sub});
    chk("we_nxt", {31'b0, mem_we}, {31'b0, sub});
    chk("misalign", {31'b0, misalign_err}, {31'b0, m});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, !we && !m});
    if (!we && !m) last_rd = exp;
    chk("rsp_rdata", rsp_rdata, last_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rvalid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, misalign_err}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    for (int i = 0; i < 32; i++) op(1, 2, 0, i * 4, $urandom);
    op(1, 2, 0, 32'h08, 32'hDEADBEEF);
    op(0, 2, 0, 32'h08, 0);
    chk("w_load", rsp_rdata, 32'hDEADBEEF);
    op(1, 2, 0, 32'h0C, 32'h11223344);
    op(1, 0, 0, 32'h0D, 32'h000000AA);
    chk("b_merge", mem[3], 32'h1122AA44);
    op(0, 2, 1, 32'h0C, 0);
    op(1, 3, 0, 32'h10, 32'h80FF7F01);
    op(0, 0, 0, 32'h12, 0);
    chk("lbu", rsp_rdata, 32'h000000FF);
    op(0, 0, 1, 32'h12, 0);
    chk("lb", rsp_rdata, 32'hFFFFFFFF);
    op(0, 1, 1, 32'h12, 0);
    chk("lh", rsp_rdata, 32'hFFFF80FF);
    op(0, 1, 0, 32'h12, 0);
    chk("lhu", rsp_rdata, 32'h000080FF);
    op(1, 1, 0, 32'h05, 32'h00001234);
    chk("mis_mem", mem[1], ref_mem[1]);
    op(0, 2, 0, 32'h0A, 0);
    // Reset pulled in the middle of a halfword merge.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_addr = 32'h16; req_wdata = 32'hBEEF;
    @(negedge clk);
    chk("rm_we_acc", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rm_merge", {31'b0, req_ready}, 32'd0);
    #1 clrn = 1'b0;
    #1;
    chk("rm_we", {31'b0, mem_we}, 32'd0);
    chk("rm_ready", {31'b0, req_ready}, 32'd1);
    chk("rm_rvalid", {31'b0, rsp_valid}, 32'd0);
    chk("rm_rdata", rsp_rdata, 32'd0);
    last_rd = '0;
    @(posedge clk); #1 clrn = 1'b1;
    @(negedge clk);
    chk("rm_ready2", {31'b0, req_ready}, 32'd1);
    chk("rm_mem", mem[5], ref_mem[5]);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      op(1, 0, 0, i * 4 + ($urandom % 4), $urandom);
      op(0, 2, 0, i * 4, 0);
    end
    for (int i = 0; i < 80; i++)
      op(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), $urandom % 128, $urandom);
    for (int i = 0; i < 32; i++) chk("sweep", mem[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
